// File: rtl/arm_pkg.sv
// ============================================================================
// Module  : arm_pkg
// Purpose : Shared widths, ALU command codes, shift codes and NZCV indices.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 4;

   // Several mnemonics share an ALU operation, so plain constants are used.
   localparam logic [3:0] EXE_NOP = 4'b0000;
   localparam logic [3:0] EXE_MOV = 4'b0001;
   localparam logic [3:0] EXE_ADD = 4'b0010;
   localparam logic [3:0] EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100;
   localparam logic [3:0] EXE_SBC = 4'b0101;
   localparam logic [3:0] EXE_AND = 4'b0110;
   localparam logic [3:0] EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000;
   localparam logic [3:0] EXE_MVN = 4'b1001;
   localparam logic [3:0] EXE_CMP = EXE_SUB;
   localparam logic [3:0] EXE_TST = EXE_AND;
   localparam logic [3:0] EXE_LDR = EXE_ADD;
   localparam logic [3:0] EXE_STR = EXE_ADD;

   typedef enum logic [1:0] {
      SHIFT_LSL = 2'b00,
      SHIFT_LSR = 2'b01,
      SHIFT_ASR = 2'b10,
      SHIFT_ROR = 2'b11
   } shift_e;

   localparam int NZCV_N = 3;
   localparam int NZCV_Z = 2;
   localparam int NZCV_C = 1;
   localparam int NZCV_V = 0;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_reg_if.sv
// ============================================================================
// Module  : id_ex_stage_reg_if
// Purpose : Decode-to-execute bundle; slave is the stage register itself.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_reg_if
   import arm_pkg::*;
#(
   parameter int DATA_W = arm_pkg::DATA_W,
   parameter int REG_W  = arm_pkg::REG_W
) ();

   logic              freeze;
   logic              flush;

   logic [DATA_W-1:0] pc_in,            pc_out;
   logic              wb_en_in,         wb_en_out;
   logic              mem_r_en_in,      mem_r_en_out;
   logic              mem_w_en_in,      mem_w_en_out;
   logic              b_in,             b_out;
   logic              s_in,             s_out;
   logic [3:0]        exe_cmd_in,       exe_cmd_out;
   logic [DATA_W-1:0] val_rn_in,        val_rn_out;
   logic [DATA_W-1:0] val_rm_in,        val_rm_out;
   logic              imm_in,           imm_out;
   logic [11:0]       shift_operand_in, shift_operand_out;
   logic [23:0]       signed_imm_24_in, signed_imm_24_out;
   logic [REG_W-1:0]  dest_in,          dest_out;
   logic [REG_W-1:0]  src1_in,          src1_out;
   logic [REG_W-1:0]  src2_in,          src2_out;
   logic [3:0]        status_in,        status_out;
   logic              valid_out;

   modport slave (
      input  freeze, flush,
      input  pc_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
      input  val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm_24_in,
      input  dest_in, src1_in, src2_in, status_in,
      output pc_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out,
      output val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm_24_out,
      output dest_out, src1_out, src2_out, status_out, valid_out
   );

   modport master (
      output freeze, flush,
      output pc_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
      output val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm_24_in,
      output dest_in, src1_in, src2_in, status_in,
      input  pc_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out,
      input  val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm_24_out,
      input  dest_out, src1_out, src2_out, status_out, valid_out
   );

endinterface

`default_nettype wire

// File: rtl/id_ex_stage_reg_pipe_reg.sv
// ============================================================================
// Module  : pipe_reg
// Purpose : Width-parameterised register with sync reset, enable and clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg
   import arm_pkg::*;
#(
   parameter int W = 1
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         en_i,
   input  wire logic         clr_i,
   input  wire logic [W-1:0] d_i,
   output logic      [W-1:0] q_o
);

   logic [W-1:0] data_d;
   logic [W-1:0] data_q;

   // Clear only matters when enabled, so a stalled stage keeps a pending flush waiting.
   always_comb begin
      data_d = clr_i ? '0 : d_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
// ============================================================================
// Module  : id_ex_stage_reg
// Purpose : ID/EX pipeline register with freeze (hold) and flush (bubble).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage_reg
   import arm_pkg::*;
#(
   parameter int DATA_W = arm_pkg::DATA_W,
   parameter int REG_W  = arm_pkg::REG_W
) (
   input  wire logic       clk,
   input  wire logic       rst,
   id_ex_stage_reg_if.slave bus
);

   localparam int CTRL_W = 10;
   localparam int DATA_GRP_W = 3 * DATA_W;
   localparam int OPND_W = 1 + 12 + 24;
   localparam int REGS_W = 3 * REG_W + 4;

   logic                  en;
   logic [CTRL_W-1:0]     ctrl_d,  ctrl_q;
   logic [DATA_GRP_W-1:0] data_d,  data_q;
   logic [OPND_W-1:0]     opnd_d,  opnd_q;
   logic [REGS_W-1:0]     regs_d,  regs_q;

   assign en = ~bus.freeze;

   // A loaded instruction always marks the stage valid; flush and reset zero it.
   assign ctrl_d = {bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in, bus.b_in,
                    bus.s_in, bus.exe_cmd_in, 1'b1};
   assign data_d = {bus.pc_in, bus.val_rn_in, bus.val_rm_in};
   assign opnd_d = {bus.imm_in, bus.shift_operand_in, bus.signed_imm_24_in};
   assign regs_d = {bus.dest_in, bus.src1_in, bus.src2_in, bus.status_in};

   pipe_reg #(.W(CTRL_W)) u_ctrl (
      .clk(clk), .rst(rst), .en_i(en), .clr_i(bus.flush), .d_i(ctrl_d), .q_o(ctrl_q)
   );

   pipe_reg #(.W(DATA_GRP_W)) u_data (
      .clk(clk), .rst(rst), .en_i(en), .clr_i(bus.flush), .d_i(data_d), .q_o(data_q)
   );

   pipe_reg #(.W(OPND_W)) u_opnd (
      .clk(clk), .rst(rst), .en_i(en), .clr_i(bus.flush), .d_i(opnd_d), .q_o(opnd_q)
   );

   pipe_reg #(.W(REGS_W)) u_regs (
      .clk(clk), .rst(rst), .en_i(en), .clr_i(bus.flush), .d_i(regs_d), .q_o(regs_q)
   );

   assign {bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out, bus.b_out,
           bus.s_out, bus.exe_cmd_out, bus.valid_out} = ctrl_q;
   assign {bus.pc_out, bus.val_rn_out, bus.val_rm_out} = data_q;
   assign {bus.imm_out, bus.shift_operand_out, bus.signed_imm_24_out} = opnd_q;
   assign {bus.dest_out, bus.src1_out, bus.src2_out, bus.status_out} = regs_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
// ============================================================================
// Module  : tb_id_ex_stage_reg
// Purpose : Directed and random checks of id_ex_stage_reg against a model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage_reg;

   typedef struct packed {
      logic [31:0] pc;
      logic        wb_en;
      logic        mem_r_en;
      logic        mem_w_en;
      logic        b;
      logic        s;
      logic [3:0]  exe_cmd;
      logic [31:0] val_rn;
      logic [31:0] val_rm;
      logic        imm;
      logic [11:0] shift_operand;
      logic [23:0] signed_imm_24;
      logic [3:0]  dest;
      logic [3:0]  src1;
      logic [3:0]  src2;
      logic [3:0]  status;
      logic        valid;
   } stage_t;

   logic   clk = 1'b0;
   logic   rst;
   stage_t stim;
   stage_t exp_st;
   int     n_vec = 0;
   int     n_err = 0;

   id_ex_stage_reg_if #(.DATA_W(32), .REG_W(4)) bus ();

   id_ex_stage_reg #(.DATA_W(32), .REG_W(4)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic drive();
      bus.pc_in            = stim.pc;
      bus.wb_en_in         = stim.wb_en;
      bus.mem_r_en_in      = stim.mem_r_en;
      bus.mem_w_en_in      = stim.mem_w_en;
      bus.b_in             = stim.b;
      bus.s_in             = stim.s;
      bus.exe_cmd_in       = stim.exe_cmd;
      bus.val_rn_in        = stim.val_rn;
      bus.val_rm_in        = stim.val_rm;
      bus.imm_in           = stim.imm;
      bus.shift_operand_in = stim.shift_operand;
      bus.signed_imm_24_in = stim.signed_imm_24;
      bus.dest_in          = stim.dest;
      bus.src1_in          = stim.src1;
      bus.src2_in          = stim.src2;
      bus.status_in        = stim.status;
   endtask

   task automatic randomize_stim();
      stim = {$urandom, $urandom, $urandom, $urandom, $urandom};
      drive();
   endtask

   task automatic compare_all();
      check_eq("pc",       64'(bus.pc_out),            64'(exp_st.pc));
      check_eq("wb_en",    64'(bus.wb_en_out),         64'(exp_st.wb_en));
      check_eq("mem_r_en", 64'(bus.mem_r_en_out),      64'(exp_st.mem_r_en));
      check_eq("mem_w_en", 64'(bus.mem_w_en_out),      64'(exp_st.mem_w_en));
      check_eq("b",        64'(bus.b_out),             64'(exp_st.b));
      check_eq("s",        64'(bus.s_out),             64'(exp_st.s));
      check_eq("exe_cmd",  64'(bus.exe_cmd_out),       64'(exp_st.exe_cmd));
      check_eq("val_rn",   64'(bus.val_rn_out),        64'(exp_st.val_rn));
      check_eq("val_rm",   64'(bus.val_rm_out),        64'(exp_st.val_rm));
      check_eq("imm",      64'(bus.imm_out),           64'(exp_st.imm));
      check_eq("shift_op", 64'(bus.shift_operand_out), 64'(exp_st.shift_operand));
      check_eq("imm24",    64'(bus.signed_imm_24_out), 64'(exp_st.signed_imm_24));
      check_eq("dest",     64'(bus.dest_out),          64'(exp_st.dest));
      check_eq("src1",     64'(bus.src1_out),          64'(exp_st.src1));
      check_eq("src2",     64'(bus.src2_out),          64'(exp_st.src2));
      check_eq("status",   64'(bus.status_out),        64'(exp_st.status));
      check_eq("valid",    64'(bus.valid_out),         64'(exp_st.valid));
   endtask

   // Model: the stage holds one whole instruction record, replaced per the edge rules.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         exp_st = '0;
      end else if (!bus.freeze) begin
         if (bus.flush) begin
            exp_st = '0;
         end else begin
            exp_st       = stim;
            exp_st.valid = 1'b1;
         end
      end
      #1;
      compare_all();
   endtask

   initial begin
      rst        = 1'b1;
      bus.freeze = 1'b0;
      bus.flush  = 1'b0;
      exp_st     = '0;
      randomize_stim();
      tick();
      bus.freeze = 1'b1;
      bus.flush  = 1'b1;
      tick();
      rst        = 1'b0;
      bus.freeze = 1'b0;
      bus.flush  = 1'b0;

      // Basic load with known operand fields
      randomize_stim();
      stim.pc            = 32'h10;
      stim.val_rm        = 32'hDEADBEEF;
      stim.shift_operand = 12'h0A3;
      stim.imm           = 1'b0;
      drive();
      tick();
      check_eq("req35_pc",    64'(bus.pc_out),            64'h10);
      check_eq("req35_rm",    64'(bus.val_rm_out),        64'hDEADBEEF);
      check_eq("req35_shift", 64'(bus.shift_operand_out), 64'h0A3);
      check_eq("req35_valid", 64'(bus.valid_out),         64'h1);

      // Freeze for three cycles while inputs keep changing
      bus.freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         randomize_stim();
         tick();
         check_eq("req36_hold_pc", 64'(bus.pc_out), 64'h10);
      end
      bus.freeze = 1'b0;
      randomize_stim();
      tick();

      // Flush inserts a bubble, then the pipe refills
      randomize_stim();
      stim.wb_en    = 1'b1;
      stim.mem_w_en = 1'b1;
      drive();
      bus.flush = 1'b1;
      tick();
      check_eq("req37_valid", 64'(bus.valid_out), 64'h0);
      bus.flush = 1'b0;
      randomize_stim();
      tick();
      check_eq("req37_reload", 64'(bus.valid_out), 64'h1);

      // Flush under freeze waits for freeze to fall
      bus.flush  = 1'b1;
      bus.freeze = 1'b1;
      for (int i = 0; i < 2; i++) begin
         randomize_stim();
         tick();
         check_eq("req38_hold_valid", 64'(bus.valid_out), 64'h1);
      end
      bus.freeze = 1'b0;
      randomize_stim();
      tick();
      check_eq("req38_zero_valid", 64'(bus.valid_out), 64'h0);
      bus.flush = 1'b0;

      // Reset during a stall drops the held instruction
      randomize_stim();
      tick();
      bus.freeze = 1'b1;
      rst        = 1'b1;
      randomize_stim();
      tick();
      check_eq("req39_valid", 64'(bus.valid_out), 64'h0);
      rst        = 1'b0;
      bus.freeze = 1'b0;
      randomize_stim();
      tick();
      check_eq("req39_reload_pc", 64'(bus.pc_out), 64'(stim.pc));

      // Random mix of load, freeze, flush and reset
      for (int i = 0; i < 400; i++) begin
         randomize_stim();
         rst        = ($urandom_range(0, 39) == 0);
         bus.freeze = ($urandom_range(0, 3) == 0);
         bus.flush  = ($urandom_range(0, 5) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register-value and PC width.
REQ-002 Parameter REG_W, default 4, SHALL set the register-index width.
REQ-003 One clock, clk; reset rst SHALL be synchronous, active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 freeze  in  1  memory stall; hold all outputs.
REQ-007 flush  in  1  taken branch in EXE; insert bubble.
REQ-008 pc_in / pc_out  in/out  DATA_W  instruction PC+4.
REQ-009 wb_en_in / wb_en_out  in/out  1  register write-back enable.
REQ-010 mem_r_en_in / mem_r_en_out  in/out  1  load.
REQ-011 mem_w_en_in / mem_w_en_out  in/out  1  store.
REQ-012 b_in / b_out  in/out  1  branch.
REQ-013 s_in / s_out  in/out  1  update status flags.
REQ-014 exe_cmd_in / exe_cmd_out  in/out  4  ALU command.
REQ-015 val_rn_in / val_rn_out  in/out  DATA_W  first operand.
REQ-016 val_rm_in / val_rm_out  in/out  DATA_W  Rm value for the second-operand generator.
REQ-017 imm_in / imm_out  in/out  1  immediate-operand flag.
REQ-018 shift_operand_in / shift_operand_out  in/out  12  instruction bits [11:0].
REQ-019 signed_imm_24_in / signed_imm_24_out  in/out  24  branch offset.
REQ-020 dest_in, src1_in, src2_in / *_out  in/out  REG_W each  destination and source indices for forwarding.
REQ-021 status_in / status_out  in/out  4  NZCV sampled at decode.
REQ-022 valid_out  out  1  stage holds a real instruction.

Function
REQ-023 Per-edge priority SHALL be rst > freeze > flush > load.
REQ-024 Load: every *_out SHALL equal its *_in from the previous edge, and valid_out SHALL be 1, giving 1-cycle latency.
REQ-025 Freeze: every output SHALL hold its value for each cycle freeze is high, with no cycle limit.
REQ-026 Flush without freeze: every output SHALL become 0, including valid_out, for one cycle.
REQ-027 Flush and freeze together: outputs SHALL hold; the flush SHALL take effect only on a later edge where freeze is low.
REQ-028 imm, shift_operand and val_rm SHALL pass bit-exact; this stage SHALL NOT decode or sign-extend them.
REQ-029 Simultaneous mem_r_en_in and mem_w_en_in SHALL be registered unchanged; arbitration is out of scope.
REQ-030 No combinational path SHALL exist from any input to any output.

Reset
REQ-031 With rst high at an edge, every output SHALL be 0, regardless of freeze and flush.
REQ-032 Reset asserted mid-stall SHALL clear the held instruction; the first edge after rst falls SHALL perform a normal load.

Structure
REQ-033 Package arm_pkg SHALL hold the EXE_CMD codes, the shift codes LSL=00, LSR=01, ASR=10, ROR=11, NZCV bit indices, and DATA_W and REG_W.
REQ-034 One sub-module, pipe_reg, SHALL be used: a width-parameterised register with rst, en (~freeze) and clr (flush), instanced once per field group.

Verification
REQ-035 Load pc_in=0x10, val_rm_in=0xDEADBEEF, shift_operand_in=0x0A3, imm_in=0 -> next cycle the outputs match and valid_out=1.
REQ-036 Freeze high 3 cycles while inputs change -> outputs hold the pre-freeze values all 3 cycles, then take the new inputs 1 cycle after freeze falls.
REQ-037 Flush with wb_en_in=1, mem_w_en_in=1 -> next cycle all outputs are 0 and valid_out=0; the following cycle loads normally.
REQ-038 Flush and freeze high together for 2 cycles, then freeze low with flush still high -> hold 2 cycles, then zero.
REQ-039 rst pulsed during freeze with valid_out=1 -> next cycle all outputs are 0; after rst falls the first edge loads the inputs.
